muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, the cycles from operands applied at mul_ina/mul_inb to a valid mul_result.
REQ-002 SHALL use clock clk with one clock domain; reset is rst, synchronous and active-high.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 flush  in  1  kills the EX-stage instruction this cycle.
REQ-006 ex_hold  in  1  pipeline is stalled by another source, so the EX stage does not advance this cycle.
REQ-007 op  in  3  operation code of the EX-stage instruction: NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO.
REQ-008 src1, src2  in  32 each  operands rs and rt.
REQ-009 mul_signed  out  1; mul_ina, mul_inb  out  32 each  multiplier controls; mul_result  in  64  product.
REQ-010 div_start  out  1; div_signed  out  1; div_annul  out  1; div_opdata1, div_opdata2  out  32 each  divider controls.
REQ-011 div_ready  in  1  divider result valid; div_result  in  64  {remainder[63:32], quotient[31:0]}.
REQ-012 stallreq  out  1  asks the pipeline to hold the IF/ID/EX stages.
REQ-013 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement the states IDLE, MUL_WAIT, DIV_WAIT and DONE.
REQ-015 In IDLE with op=MTHI or MTLO, SHALL write src1 to hi or lo at the next clock edge.
- The write completes in one cycle, with no stall and no state change.
REQ-016 In IDLE with op=MULT or MULTU:
- drive mul_ina=src1 and mul_inb=src2;
- set mul_signed=(op==MULT);
- load the latency counter with MUL_LAT-1, assert stallreq, and go to MUL_WAIT.
REQ-017 In MUL_WAIT, SHALL decrement the counter each cycle and hold stallreq=1.
- At counter 0: {hi,lo}<=mul_result, stallreq=0 that cycle, go to DONE.
- MUL_LAT=2 therefore stalls for exactly 2 cycles.
REQ-018 In IDLE with op=DIV or DIVU and src2!=0:
- assert div_start for exactly one cycle, with div_opdata1=src1, div_opdata2=src2 and div_signed=(op==DIV);
- assert stallreq and go to DIV_WAIT.
REQ-019 In DIV_WAIT, SHALL hold the operands and div_signed stable with div_start=0 and stallreq=1 until div_ready=1.
- On that cycle: lo<=div_result[31:0], hi<=div_result[63:32], stallreq=0, go to DONE.
REQ-020 DIV or DIVU with src2==0 SHALL NOT start the divider, SHALL leave hi/lo unchanged, and SHALL NOT stall.
REQ-021 In DONE, SHALL stay in DONE while ex_hold=1 (no restart of the same instruction, no HI/LO write, stallreq=0), and go to IDLE when ex_hold=0.
REQ-022 flush=1 in MUL_WAIT or DIV_WAIT SHALL take effect that cycle:
- assert div_annul for one cycle (DIV_WAIT only);
- suppress the HI/LO write and deassert stallreq;
- go to IDLE on the next edge.
REQ-023 flush=1 in IDLE SHALL suppress the MTHI/MTLO write and not start any operation.
REQ-024 If flush and div_ready/counter-zero occur in the same cycle, flush SHALL win and HI/LO stay unchanged.
REQ-025 op=NONE or an unused encoding SHALL be ignored in IDLE.
REQ-026 Outputs not in use SHALL be 0 (div_opdata*, mul_in*, div_start, div_annul, div_signed, mul_signed).
REQ-027 hi/lo SHALL be register outputs, so a write becomes visible the cycle after the writing edge.

Reset
REQ-028 With rst=1 at a clock edge:
- state<=IDLE, counter<=0, hi<=0, lo<=0;
- all outputs 0 the following cycle, including stallreq.
REQ-029 Reset during MUL_WAIT or DIV_WAIT SHALL abandon the operation with no HI/LO write; the divider is reset by the same rst.

Structure
REQ-030 The op encodings SHALL be shared constants in the common defines header:
- MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
REQ-031 State encodings and MUL_LAT's default SHALL live in the same header.
REQ-032 The HI/LO register pair SHALL be a sub-module, hilo_reg (write-enable per half, synchronous reset).
REQ-033 The mul and div units SHALL be instantiated outside, at the EX level; this block only sequences them.

Verification
REQ-034 MULT src1=0xFFFFFFFE, src2=3 -> stallreq high for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 DIV src1=-7, src2=2; div_ready after 33 cycles -> one div_start pulse, stallreq high until ready, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU 100/7 with ex_hold=1 for 3 cycles after completion:
- lo=14, hi=2;
- exactly one div_start in total;
- no second write.
REQ-038 DIV in DIV_WAIT with flush at cycle 10 -> div_annul pulse, hi/lo unchanged, IDLE next cycle, stallreq=0.
REQ-039 MTHI 0x1234 then MTLO 0x5678 back-to-back, then DIV by 0 -> hi=0x1234, lo=0x5678, no stall, no div_start.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the EX-stage HI/LO multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MUL_LAT_DEFAULT = 2;
    localparam int CNT_W           = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } md_state_t;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi_dat;
        logic [31:0] lo_dat;
    } hilo_wr_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Control/result bundle between the sequencer and the external mul/div units.
interface muldiv_ctrl_if;

    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic        div_annul;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_ready;
    logic [63:0] div_result;

    modport master (
        output mul_signed, mul_ina, mul_inb,
        output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
        input  mul_result, div_ready, div_result
    );

    modport slave (
        input  mul_signed, mul_ina, mul_inb,
        input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
        output mul_result, div_ready, div_result
    );

endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair with an independent write enable per half.
// Latency: a write is visible the cycle after the writing edge.
// Backpressure: none, writes are always accepted.
module hilo_reg
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  hilo_wr_t    wr,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (wr.hi_we) hi <= wr.hi_dat;
            if (wr.lo_we) lo <= wr.lo_dat;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequences external mul/div units for MULT/MULTU/DIV/DIVU and handles MTHI/MTLO.
// Latency: MTHI/MTLO 1 cycle; MUL stalls MUL_LAT cycles; DIV stalls until div_ready.
// Backpressure: stallreq holds IF/ID/EX; ex_hold parks the FSM in DONE.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic [2:0]    op,
    input  logic [31:0]   src1,
    input  logic [31:0]   src2,
    output logic          stallreq,
    output logic [31:0]   hi,
    output logic [31:0]   lo,
    muldiv_ctrl_if.master md
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      opa_q, opa_nxt;
    logic [31:0]      opb_q, opb_nxt;
    logic             sgn_q, sgn_nxt;
    hilo_wr_t         wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            opa_q <= opa_nxt;
            opb_q <= opb_nxt;
            sgn_q <= sgn_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        opa_nxt        = opa_q;
        opb_nxt        = opb_q;
        sgn_nxt        = sgn_q;
        stallreq       = 1'b0;
        wr             = '0;
        md.mul_signed  = 1'b0;
        md.mul_ina     = '0;
        md.mul_inb     = '0;
        md.div_start   = 1'b0;
        md.div_signed  = 1'b0;
        md.div_annul   = 1'b0;
        md.div_opdata1 = '0;
        md.div_opdata2 = '0;

        case (state)
            ST_IDLE: begin
                if (!flush) begin
                    case (op)
                        MD_MTHI: begin
                            wr.hi_we  = 1'b1;
                            wr.hi_dat = src1;
                        end
                        MD_MTLO: begin
                            wr.lo_we  = 1'b1;
                            wr.lo_dat = src1;
                        end
                        MD_MULT, MD_MULTU: begin
                            md.mul_ina    = src1;
                            md.mul_inb    = src2;
                            md.mul_signed = (op == MD_MULT);
                            opa_nxt       = src1;
                            opb_nxt       = src2;
                            sgn_nxt       = (op == MD_MULT);
                            cnt_nxt       = CNT_W'(MUL_LAT - 1);
                            stallreq      = 1'b1;
                            state_nxt     = ST_MUL_WAIT;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero is a silent no-op: HI/LO keep their values.
                            if (src2 != '0) begin
                                md.div_start   = 1'b1;
                                md.div_opdata1 = src1;
                                md.div_opdata2 = src2;
                                md.div_signed  = (op == MD_DIV);
                                opa_nxt        = src1;
                                opb_nxt        = src2;
                                sgn_nxt        = (op == MD_DIV);
                                stallreq       = 1'b1;
                                state_nxt      = ST_DIV_WAIT;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL_WAIT: begin
                md.mul_ina    = opa_q;
                md.mul_inb    = opb_q;
                md.mul_signed = sgn_q;
                if (flush) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    wr.hi_we  = 1'b1;
                    wr.lo_we  = 1'b1;
                    wr.hi_dat = md.mul_result[63:32];
                    wr.lo_dat = md.mul_result[31:0];
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    stallreq = 1'b1;
                end
            end

            ST_DIV_WAIT: begin
                md.div_opdata1 = opa_q;
                md.div_opdata2 = opb_q;
                md.div_signed  = sgn_q;
                // A kill beats a same-cycle div_ready so the squashed result never lands.
                if (flush) begin
                    md.div_annul = 1'b1;
                    state_nxt    = ST_IDLE;
                end else if (md.div_ready) begin
                    wr.hi_we  = 1'b1;
                    wr.lo_we  = 1'b1;
                    wr.hi_dat = md.div_result[63:32];
                    wr.lo_dat = md.div_result[31:0];
                    state_nxt = ST_DONE;
                end else begin
                    stallreq = 1'b1;
                end
            end

            ST_DONE: begin
                if (!ex_hold) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    hilo_reg u_hilo (
        .clk (clk),
        .rst (rst),
        .wr  (wr),
        .hi  (hi),
        .lo  (lo)
    );

endmodule
